// File: rtl/iter_arith_unit_if.sv
// Request/response bus for the shared arithmetic unit: valid/ready request side
// carrying op and operands, valid/ready response side carrying result, remainder and flag.
interface iter_arith_unit_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         op;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   rem;
  logic               div_zero;

  modport master (
    output in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, result, rem, div_zero
  );

  modport slave (
    input  in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, result, rem, div_zero
  );
endinterface

// File: rtl/iter_arith_unit.sv
// Shared add/sub/mul/div unit, one op in flight: add/sub resolve at accept,
// mul (shift-add, LSB first) and div (restoring, MSB first) iterate WIDTH cycles.
module iter_arith_unit #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  iter_arith_unit_if.slave bus
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] result_q;
  logic [WIDTH-1:0]   rem_q;
  logic               dz_q;

  logic               accept;
  logic               last_iter;
  logic               in_ready_c;
  logic               out_valid_c;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    last_iter   = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        accept     = bus.in_valid;
        if (bus.in_valid) begin
          state_nxt = bus.op[1] ? CALC : DONE;
        end
      end
      CALC: begin
        last_iter = (cnt == CNT_W'(WIDTH - 1));
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // acc holds {partial product high, remaining multiplier} for mul
  // and {partial remainder, dividend/quotient shift register} for div.
  always_comb begin
    add_sum   = {1'b0, bus.in1} + {1'b0, bus.in2};
    sub_diff  = {1'b0, bus.in1} - {1'b0, bus.in2};
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
    div_ge    = (div_shift >= {1'b0, b_q});
    if (op_q == OP_DIV) begin
      acc_nxt = {(div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc[WIDTH-2:0], div_ge};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      result_q <= '0;
      rem_q    <= '0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      op_q <= bus.op;
      a_q  <= bus.in1;
      b_q  <= bus.in2;
      cnt  <= '0;
      acc  <= (bus.op == OP_DIV) ? {{WIDTH{1'b0}}, bus.in1} : {{WIDTH{1'b0}}, bus.in2};
      if (!bus.op[1]) begin
        result_q <= (bus.op == OP_SUB) ? {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff}
                                       : {{(WIDTH-1){1'b0}}, add_sum};
        rem_q    <= '0;
        dz_q     <= 1'b0;
      end
    end else if (state == CALC) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last_iter) begin
        if (op_q == OP_DIV) begin
          // Divisor zero needs no special path: every trial succeeds,
          // giving an all-ones quotient and the dividend as remainder.
          result_q <= {{WIDTH{1'b0}}, acc_nxt[WIDTH-1:0]};
          rem_q    <= acc_nxt[2*WIDTH-1:WIDTH];
          dz_q     <= (b_q == '0);
        end else begin
          result_q <= acc_nxt;
          rem_q    <= '0;
          dz_q     <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;
  assign bus.rem       = rem_q;
  assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_iter_arith_unit.sv
// Bench for iter_arith_unit: WIDTH=8 and WIDTH=16 instances checked against a
// plain-arithmetic reference model, plus latency, backpressure and reset scenarios.
module tb_iter_arith_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  iter_arith_unit_if #(.WIDTH(8))  bus8 ();
  iter_arith_unit_if #(.WIDTH(16)) bus16 ();

  iter_arith_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  iter_arith_unit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  function automatic void model(input int w, input logic [1:0] op,
                                input longint unsigned a, input longint unsigned b,
                                output longint unsigned res, output longint unsigned rm,
                                output logic dz);
    longint unsigned mask2 = (64'd1 << (2 * w)) - 1;
    longint unsigned maskw = (64'd1 << w) - 1;
    rm = 0;
    dz = 1'b0;
    case (op)
      2'b00: res = a + b;
      2'b01: res = (a - b) & mask2;
      2'b10: res = a * b;
      default: begin
        if (b == 0) begin
          res = maskw;
          rm  = a;
          dz  = 1'b1;
        end else begin
          res = a / b;
          rm  = a % b;
        end
      end
    endcase
  endfunction

  task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [15:0] res, output logic [7:0] rm,
                        output logic dz);
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.op = op; bus8.in1 = a; bus8.in2 = b; bus8.out_ready = 1'b1;
    for (int t = 0; t < 50 && !bus8.in_ready; t++) @(negedge clk);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.op = 2'($urandom); bus8.in1 = 8'($urandom); bus8.in2 = 8'($urandom);
    lat = -1;
    for (int t = 1; t <= 64; t++) begin
      @(negedge clk);
      if (bus8.out_valid) begin lat = t; break; end
    end
    res = bus8.result; rm = bus8.rem; dz = bus8.div_zero;
    @(posedge clk);
  endtask

  task automatic issue16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [31:0] res, output logic [15:0] rm,
                         output logic dz);
    @(negedge clk);
    bus16.in_valid = 1'b1; bus16.op = op; bus16.in1 = a; bus16.in2 = b; bus16.out_ready = 1'b1;
    for (int t = 0; t < 50 && !bus16.in_ready; t++) @(negedge clk);
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    bus16.op = 2'($urandom); bus16.in1 = 16'($urandom); bus16.in2 = 16'($urandom);
    lat = -1;
    for (int t = 1; t <= 64; t++) begin
      @(negedge clk);
      if (bus16.out_valid) begin lat = t; break; end
    end
    res = bus16.result; rm = bus16.rem; dz = bus16.div_zero;
    @(posedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks += 5;
    if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus8.in_ready); end
    if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus8.out_valid); end
    if (bus8.result !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus8.result); end
    if (bus8.rem !== 8'h0) begin errors++; $display("FAIL reset_rem got %h want 0", bus8.rem); end
    if (bus8.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b want 0", bus8.div_zero); end
  endtask

  // Directed vectors with spec-given constants, plus model cross-check.
  task automatic test_directed();
    logic [1:0]  ops [8] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [7:0]  as  [8] = '{8'd160, 8'd20, 8'd255, 8'd0,   8'd160, 8'd255, 8'd80, 8'd7};
    logic [7:0]  bs  [8] = '{8'd70,  8'd30, 8'd255, 8'd255, 8'd70,  8'd255, 8'd30, 8'd0};
    logic [15:0] ers [8] = '{16'd230, 16'hFFF6, 16'h01FE, 16'hFF01, 16'h2BC0, 16'hFE01, 16'd2, 16'h00FF};
    logic [7:0]  erm [8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20, 8'd7};
    logic        edz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat; logic [15:0] res; logic [7:0] rm; logic dz;
    for (int i = 0; i < 8; i++) begin
      issue8(ops[i], as[i], bs[i], lat, res, rm, dz);
      checks += 4;
      if (res !== ers[i]) begin errors++; $display("FAIL directed%0d_result got %h want %h", i, res, ers[i]); end
      if (rm !== erm[i]) begin errors++; $display("FAIL directed%0d_rem got %0d want %0d", i, rm, erm[i]); end
      if (dz !== edz[i]) begin errors++; $display("FAIL directed%0d_div_zero got %b want %b", i, dz, edz[i]); end
      if (lat !== (ops[i][1] ? 9 : 1)) begin errors++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, ops[i][1] ? 9 : 1); end
    end
  endtask

  task automatic test_backpressure();
    int lat = -1;
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.op = 2'b10; bus8.in1 = 8'd40; bus8.in2 = 8'd30; bus8.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    for (int t = 1; t <= 64; t++) begin
      @(negedge clk);
      bus8.op = 2'($urandom); bus8.in1 = 8'($urandom); bus8.in2 = 8'($urandom);
      if (bus8.out_valid) begin lat = t; break; end
    end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL bp_latency got %0d want 9", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 3;
      if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b want 1", bus8.out_valid); end
      if (bus8.result !== 16'd1200) begin errors++; $display("FAIL bp_hold_result got %0d want 1200", bus8.result); end
      if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", bus8.in_ready); end
    end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    checks += 3;
    if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b want 1", bus8.in_ready); end
    if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b want 0", bus8.out_valid); end
    if (bus8.result !== 16'd1200) begin errors++; $display("FAIL bp_result_kept got %0d want 1200", bus8.result); end
  endtask

  task automatic test_reset_midop();
    int lat; logic [15:0] res; logic [7:0] rm; logic dz;
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.op = 2'b11; bus8.in1 = 8'd200; bus8.in2 = 8'd7; bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", bus8.in_ready); end
    if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", bus8.out_valid); end
    if (bus8.result !== 16'h0) begin errors++; $display("FAIL midrst_result got %h want 0", bus8.result); end
    if (bus8.rem !== 8'h0) begin errors++; $display("FAIL midrst_rem got %h want 0", bus8.rem); end
    @(negedge clk);
    rst = 1'b0;
    issue8(2'b00, 8'd20, 8'd10, lat, res, rm, dz);
    checks += 2;
    if (res !== 16'd30) begin errors++; $display("FAIL midrst_add got %0d want 30", res); end
    if (lat !== 1) begin errors++; $display("FAIL midrst_add_latency got %0d want 1", lat); end
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'd0;
      1: return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic test_random();
    int lat; logic [15:0] res; logic [7:0] rm; logic dz;
    longint unsigned eres, erm; logic edz;
    logic [1:0] op; logic [7:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3)); a = pick8(); b = pick8();
      issue8(op, a, b, lat, res, rm, dz);
      model(8, op, longint'(a), longint'(b), eres, erm, edz);
      checks += 4;
      if (res !== eres[15:0]) begin errors++; $display("FAIL rand op=%0d %0d,%0d result got %h want %h", op, a, b, res, eres[15:0]); end
      if (rm !== erm[7:0]) begin errors++; $display("FAIL rand op=%0d %0d,%0d rem got %0d want %0d", op, a, b, rm, erm[7:0]); end
      if (dz !== edz) begin errors++; $display("FAIL rand op=%0d %0d,%0d div_zero got %b want %b", op, a, b, dz, edz); end
      if (lat !== (op[1] ? 9 : 1)) begin errors++; $display("FAIL rand op=%0d latency got %0d", op, lat); end
    end
  endtask

  task automatic test_width16();
    int lat; logic [31:0] res; logic [15:0] rm; logic dz;
    longint unsigned eres, erm; logic edz;
    logic [1:0] op; logic [15:0] a, b;
    issue16(2'b10, 16'hFFFF, 16'hFFFF, lat, res, rm, dz);
    checks += 2;
    if (res !== 32'hFFFE0001) begin errors++; $display("FAIL w16_mul got %h want FFFE0001", res); end
    if (lat !== 17) begin errors++; $display("FAIL w16_mul_latency got %0d want 17", lat); end
    issue16(2'b11, 16'd65535, 16'd256, lat, res, rm, dz);
    checks += 3;
    if (res !== 32'd255) begin errors++; $display("FAIL w16_div got %0d want 255", res); end
    if (rm !== 16'd255) begin errors++; $display("FAIL w16_div_rem got %0d want 255", rm); end
    if (lat !== 17) begin errors++; $display("FAIL w16_div_latency got %0d want 17", lat); end
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3)); a = 16'($urandom); b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      issue16(op, a, b, lat, res, rm, dz);
      model(16, op, longint'(a), longint'(b), eres, erm, edz);
      checks += 3;
      if (res !== eres[31:0]) begin errors++; $display("FAIL w16_rand op=%0d %0d,%0d result got %h want %h", op, a, b, res, eres[31:0]); end
      if (rm !== erm[15:0]) begin errors++; $display("FAIL w16_rand op=%0d rem got %0d want %0d", op, rm, erm[15:0]); end
      if (dz !== edz) begin errors++; $display("FAIL w16_rand op=%0d div_zero got %b want %b", op, dz, edz); end
    end
  endtask

  initial begin
    bus8.in_valid = 1'b0; bus8.op = 2'b00; bus8.in1 = '0; bus8.in2 = '0; bus8.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.op = 2'b00; bus16.in1 = '0; bus16.in2 = '0; bus16.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_random();
    test_width16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
